// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response and the decode-side handshake.
// master = fetch_unit, slave = memory plus decode.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid_o;
  logic            imem_req_ready_i;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_rsp_valid_i;
  logic [31:0]     imem_rsp_data_i;
  logic            if_valid_o;
  logic            if_ready_i;
  logic [XLEN-1:0] if_pc_o;
  logic [31:0]     if_inst_o;

  modport master (
    output imem_req_valid_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o,
    input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, if_ready_i
  );

  modport slave (
    input  imem_req_valid_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o,
    output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, if_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one memory request in flight and holds
// one fetched instruction for decode; redirects from execute kill wrong-path fetches.
//
// state | meaning
// REQ   | present pc_q to memory when the output buffer has room
// WAIT  | request accepted, response will be kept
// KILL  | request accepted before a redirect, response will be dropped
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  fetch_unit_if.master    bus
);

  typedef enum logic [1:0] {REQ, WAIT, KILL} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            run_q;
  logic            req_valid, req_fire, load;
  logic            buf_valid_q;
  logic [XLEN-1:0] buf_pc_q;
  logic [31:0]     buf_inst_q;

  // run_q keeps the request low during reset and for the release cycle itself
  assign req_valid = run_q && (state_q == REQ) && (!buf_valid_q || bus.if_ready_i);
  assign req_fire  = req_valid && bus.imem_req_ready_i;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    load     = 1'b0;
    unique case (state_q)
      REQ: begin
        if (req_fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(4);
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid_i) begin
          load    = 1'b1;
          state_d = REQ;
        end
      end
      KILL: begin
        if (bus.imem_rsp_valid_i) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
    // a redirect turns any still-outstanding request into a killed one
    if (br_taken_i) begin
      pc_d = {br_target_i[XLEN-1:2], 2'b00};
      if (state_d == WAIT) state_d = KILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      run_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= '0;
    end else if (br_taken_i) begin
      buf_valid_q <= 1'b0;
    end else if (load) begin
      buf_valid_q <= 1'b1;
      buf_pc_q    <= req_pc_q;
      buf_inst_q  <= bus.imem_rsp_data_i;
    end else if (buf_valid_q && bus.if_ready_i) begin
      buf_valid_q <= 1'b0;
    end
  end

  assign bus.imem_req_valid_o = req_valid;
  assign bus.imem_addr_o      = pc_q;
  assign bus.if_valid_o       = buf_valid_q;
  assign bus.if_pc_o          = buf_pc_q;
  assign bus.if_inst_o        = buf_inst_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model, request/output scoreboards,
// directed cycle checks around stalls, redirects, reset and PC wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_taken2;
  logic [31:0] br_target2;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [31:0] exp_req[$];
  logic [31:0] exp_out[$];

  fetch_unit_if #(.XLEN(32)) f1 ();
  fetch_unit_if #(.XLEN(32)) f2 ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .br_taken_i  (br_taken),
    .br_target_i (br_target),
    .bus         (f1)
  );

  fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .br_taken_i  (br_taken2),
    .br_target_i (br_target2),
    .bus         (f2)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic at_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // memory model for the main DUT: one response lat cycles after each accepted request
  initial begin
    bit          pend = 0;
    int          cnt  = 0;
    logic [31:0] paddr = '0;
    logic [31:0] e;
    f1.imem_rsp_valid_i = 1'b0;
    f1.imem_rsp_data_i  = '0;
    forever begin
      @(posedge clk);
      #1;
      f1.imem_rsp_valid_i = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          f1.imem_rsp_valid_i = 1'b1;
          f1.imem_rsp_data_i  = word(paddr);
          pend = 0;
        end else begin
          cnt--;
        end
      end
      @(negedge clk);
      if (rst_n && f1.imem_req_valid_o && f1.imem_req_ready_i) begin
        if (exp_req.size() == 0) chk("req_extra", {32'h0, f1.imem_addr_o}, 64'hFFFF_FFFF);
        else begin
          e = exp_req.pop_front();
          chk("req_addr", {32'h0, f1.imem_addr_o}, {32'h0, e});
        end
        pend  = 1;
        cnt   = lat;
        paddr = f1.imem_addr_o;
      end
    end
  end

  // decode-side scoreboard
  initial forever begin
    logic [31:0] e;
    @(negedge clk);
    if (rst_n && f1.if_valid_o && f1.if_ready_i) begin
      if (exp_out.size() == 0) chk("out_extra", {32'h0, f1.if_pc_o}, 64'hFFFF_FFFF);
      else begin
        e = exp_out.pop_front();
        chk("out_pc", {32'h0, f1.if_pc_o}, {32'h0, e});
        chk("out_inst", {32'h0, f1.if_inst_o}, {32'h0, word(e)});
      end
    end
  end

  // wrap instance: always-ready memory with one-cycle latency
  always @(posedge clk) begin
    f2.imem_rsp_valid_i <= f2.imem_req_valid_o && f2.imem_req_ready_i;
    f2.imem_rsp_data_i  <= f2.imem_addr_o;
  end

  initial begin
    #200000;
    $display("FAIL timeout (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;
    br_taken2  = 1'b0;
    br_target2 = '0;
    f1.imem_req_ready_i = 1'b1;
    f1.if_ready_i       = 1'b1;
    f2.imem_req_ready_i = 1'b1;
    f2.if_ready_i       = 1'b1;

    @(negedge clk);
    chk("rst_req_valid", {63'h0, f1.imem_req_valid_o}, 64'h0);
    chk("rst_addr",      {32'h0, f1.imem_addr_o}, 64'h0);
    chk("rst_if_valid",  {63'h0, f1.if_valid_o}, 64'h0);
    chk("rst_if_pc_inst", {f1.if_pc_o, f1.if_inst_o}, 64'h0);
    chk("rst_wrap_addr", {31'h0, f2.imem_req_valid_o, f2.imem_addr_o}, {31'h0, 1'b0, 32'hFFFF_FFFC});

    // streaming fetch, k=1, decode always ready
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    exp_out.push_back(32'h0); exp_out.push_back(32'h4);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc   = 0;
    @(negedge clk);
    chk("t1_c0_idle", {63'h0, f1.imem_req_valid_o}, 64'h0);
    at_cyc(1); @(negedge clk);
    chk("t1_c1_req", {31'h0, f1.imem_req_valid_o, f1.imem_addr_o}, {31'h0, 1'b1, 32'h0});
    chk("wrap_req1", {31'h0, f2.imem_req_valid_o, f2.imem_addr_o}, {31'h0, 1'b1, 32'hFFFF_FFFC});
    at_cyc(2); @(negedge clk);
    chk("t1_c2_noreq", {62'h0, f1.imem_req_valid_o, f1.if_valid_o}, 64'h0);
    at_cyc(3); @(negedge clk);
    chk("t1_c3_req", {31'h0, f1.imem_req_valid_o, f1.imem_addr_o}, {31'h0, 1'b1, 32'h4});
    chk("t1_c3_out", {31'h0, f1.if_valid_o, f1.if_pc_o}, {31'h0, 1'b1, 32'h0});
    chk("wrap_req2", {31'h0, f2.imem_req_valid_o, f2.imem_addr_o}, {31'h0, 1'b1, 32'h0});
    at_cyc(5);
    lat = 4;
    @(negedge clk);
    chk("t1_c5_req", {31'h0, f1.imem_req_valid_o, f1.imem_addr_o}, {31'h0, 1'b1, 32'h8});
    chk("t1_c5_out", {31'h0, f1.if_valid_o, f1.if_pc_o}, {31'h0, 1'b1, 32'h4});

    // reset in the middle of an outstanding fetch; its response lands after release
    at_cyc(6);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, f1.imem_req_valid_o, f1.imem_addr_o}, 64'h0);
    chk("mid_rst_buf", {31'h0, f1.if_valid_o, f1.if_pc_o}, 64'h0);
    lat = 1;
    at_cyc(8);
    rst_n = 1'b1;
    cyc   = 0;

    // decode stall holding PC 0x4
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    exp_out.push_back(32'h0); exp_out.push_back(32'h4);
    at_cyc(2); @(negedge clk);
    chk("stray_rsp_ignored", {63'h0, f1.if_valid_o}, 64'h0);
    at_cyc(5);
    f1.if_ready_i = 1'b0;
    for (int c = 5; c <= 8; c++) begin
      at_cyc(c); @(negedge clk);
      chk("stall_hold", {f1.imem_req_valid_o, f1.if_valid_o, f1.if_pc_o[29:0], f1.if_inst_o},
          {1'b0, 1'b1, 30'h4, word(32'h4)});
    end
    at_cyc(9);
    f1.if_ready_i = 1'b1;
    lat = 3;
    @(negedge clk);
    chk("stall_release_req", {31'h0, f1.imem_req_valid_o, f1.imem_addr_o}, {31'h0, 1'b1, 32'h8});

    // redirect while waiting on a k=3 response
    exp_req.push_back(32'h100);
    exp_out.push_back(32'h100);
    at_cyc(10);
    br_taken  = 1'b1;
    br_target = 32'h100;
    at_cyc(11);
    br_taken = 1'b0;
    lat      = 1;
    @(negedge clk);
    chk("wait_redir_kill", {62'h0, f1.imem_req_valid_o, f1.if_valid_o}, 64'h0);
    at_cyc(12); @(negedge clk);
    chk("kill_drop_rsp", {62'h0, f1.imem_req_valid_o, f1.if_valid_o}, 64'h0);
    at_cyc(13); @(negedge clk);
    chk("redir_target_req", {31'h0, f1.imem_req_valid_o, f1.imem_addr_o}, {31'h0, 1'b1, 32'h100});

    // redirect on the handshake cycle, unaligned target
    exp_req.push_back(32'h104); exp_req.push_back(32'h200);
    exp_out.push_back(32'h200);
    at_cyc(15);
    br_taken  = 1'b1;
    br_target = 32'h203;
    lat       = 2;
    at_cyc(16);
    br_taken = 1'b0;
    lat      = 1;
    @(negedge clk);
    chk("hs_redir_kill", {62'h0, f1.imem_req_valid_o, f1.if_valid_o}, 64'h0);
    at_cyc(17); @(negedge clk);
    chk("hs_redir_drop", {62'h0, f1.imem_req_valid_o, f1.if_valid_o}, 64'h0);
    at_cyc(18); @(negedge clk);
    chk("aligned_target_req", {31'h0, f1.imem_req_valid_o, f1.imem_addr_o}, {31'h0, 1'b1, 32'h200});

    // redirect in the same cycle the response arrives
    exp_req.push_back(32'h204); exp_req.push_back(32'h300);
    exp_out.push_back(32'h300);
    at_cyc(21);
    br_taken  = 1'b1;
    br_target = 32'h300;
    at_cyc(22);
    br_taken = 1'b0;
    @(negedge clk);
    chk("rsp_redir_buf", {63'h0, f1.if_valid_o}, 64'h0);
    chk("rsp_redir_req", {31'h0, f1.imem_req_valid_o, f1.imem_addr_o}, {31'h0, 1'b1, 32'h300});

    // request held off by memory: address must stay put
    at_cyc(24);
    f1.imem_req_ready_i = 1'b0;
    for (int c = 25; c <= 26; c++) begin
      at_cyc(c); @(negedge clk);
      chk("addr_stable", {31'h0, f1.imem_req_valid_o, f1.imem_addr_o}, {31'h0, 1'b1, 32'h304});
    end

    at_cyc(28);
    chk("req_queue_drained", 64'(exp_req.size()), 64'h0);
    chk("out_queue_drained", 64'(exp_out.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
